multiplicand_divisor_shift_register: RTL and testbench

MULTIPLICAND_DIVISOR_SHIFT_REGISTER -- requirements
Module: multiplicand_divisor_shift_register

---
 rtl/mul_div_pkg.sv | 6 +
 rtl/mul_div_step_counter.sv | 20 ++
 rtl/multiplicand_divisor_shift_register.sv | 68 ++++++
 tb/tb_multiplicand_divisor_shift_register.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared FSM states and operation encodings for the shift register.
package mul_div_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/mul_div_step_counter.sv
// mul_div_step_counter: shift counter flagging when the next increment reaches the limit.
module mul_div_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else if (clear) count_q <= '0;
    else if (inc) count_q <= count_q + 1'b1;
  assign count    = count_q;
  assign at_limit = (count_q == limit - 1'b1);
endmodule

// File: rtl/multiplicand_divisor_shift_register.sv
// multiplicand_divisor_shift_register: 2*WIDTH operand register shifting left (multiply) or right (divide).
module multiplicand_divisor_shift_register
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               step,
  input  logic               abort,
  output logic [2*WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]   step_count,
  output logic               busy,
  output logic               done
);
  state_e             state_q;
  logic               op_q;
  logic [2*WIDTH-1:0] data_q, data_d;
  logic               load, kill, shift, at_limit;
  logic [CNT_W-1:0]   limit;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign load       = load_valid & load_ready;
  assign kill       = busy & abort;
  assign shift      = busy & step & ~abort;
  // Divide needs one extra shift so the divisor ends aligned below the dividend MSB.
  assign limit = (op_q == OP_DIV) ? CNT_W'(WIDTH + 1) : CNT_W'(WIDTH);
  always_comb begin
    data_d = load  ? ((op == OP_DIV) ? {data_in, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, data_in})
           : kill  ? '0
           : shift ? ((op_q == OP_DIV) ? data_q >> 1 : data_q << 1)
           : data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) data_q <= '0;
    else data_q <= data_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
    end else begin
      case (state_q)
        IDLE:  if (load) begin
                 state_q <= SHIFT;
                 op_q    <= op;
               end
        SHIFT: if (abort) state_q <= IDLE;
               else if (step && at_limit) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  mul_div_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (load | kill),
    .inc      (shift),
    .limit    (limit),
    .count    (step_count),
    .at_limit (at_limit)
  );
  assign data_out = data_q;
endmodule

// File: tb/tb_multiplicand_divisor_shift_register.sv
// tb_multiplicand_divisor_shift_register: directed checks on WIDTH=8 and WIDTH=64 instances.
module tb_multiplicand_divisor_shift_register;
  logic clk = 1'b0, reset = 1'b1;
  logic lv8 = 0, op8 = 0, st8 = 0, ab8 = 0;
  logic [7:0] din8 = '0;
  logic rdy8, busy8, done8;
  logic [15:0] dout8;
  logic [3:0] cnt8;
  logic lv64 = 0, op64 = 0, st64 = 0, ab64 = 0;
  logic [63:0] din64 = '0;
  logic rdy64, busy64, done64;
  logic [127:0] dout64;
  logic [6:0] cnt64;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  multiplicand_divisor_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(rdy8), .op(op8), .data_in(din8),
    .step(st8), .abort(ab8), .data_out(dout8), .step_count(cnt8), .busy(busy8), .done(done8));
  multiplicand_divisor_shift_register #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .load_valid(lv64), .load_ready(rdy64), .op(op64), .data_in(din64),
    .step(st64), .abort(ab64), .data_out(dout64), .step_count(cnt64), .busy(busy64), .done(done64));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int dones, done_at;
    #12;
    chk("rst_data", dout8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_rdy", rdy8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    tick();
    reset = 0; lv8 = 1; op8 = 0; din8 = 8'hA5; st8 = 1;
    tick();
    chk("mul_load", dout8, 16'h00A5);
    chk("mul_load_cnt", cnt8, 0);
    chk("mul_busy", busy8, 1);
    chk("mul_rdy", rdy8, 0);
    din8 = 8'hFF; op8 = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("mul_data%0d", i), dout8, 16'(16'h00A5 << i));
      chk($sformatf("mul_cnt%0d", i), cnt8, i);
      chk($sformatf("mul_done%0d", i), done8, i == 8);
    end
    tick();
    lv8 = 0;
    chk("mul_idle_done", done8, 0);
    chk("mul_idle_rdy", rdy8, 1);
    chk("mul_hold", dout8, 16'hA500);
    tick();
    chk("mul_hold2", dout8, 16'hA500);
    chk("mul_hold_cnt", cnt8, 8);
    lv8 = 1; op8 = 1; din8 = 8'h81; st8 = 0;
    tick();
    lv8 = 0; op8 = 0; st8 = 1;
    chk("div_load", dout8, 16'h8100);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("div_data%0d", i), dout8, 16'h8100 >> i);
      chk($sformatf("div_done%0d", i), done8, i == 9);
    end
    chk("div_cnt", cnt8, 9);
    tick();
    chk("div_after_done", done8, 0);
    st8 = 0;
    ab8 = 1;
    tick();
    chk("abort_idle_data", dout8, 16'h0040);
    chk("abort_idle_cnt", cnt8, 9);
    ab8 = 0; lv8 = 1; op8 = 0; din8 = 8'hA5; st8 = 1;
    tick();
    lv8 = 1; din8 = 8'h3C;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_abort_cnt", cnt8, 3);
    chk("pre_abort_data", dout8, 16'h0528);
    ab8 = 1;
    tick();
    ab8 = 0; lv8 = 0;
    chk("abort_data", dout8, 0);
    chk("abort_cnt", cnt8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_rdy", rdy8, 1);
    tick();
    chk("abort_no_done", done8, 0);
    lv8 = 1; din8 = 8'hA5; op8 = 0;
    tick();
    lv8 = 0;
    tick();
    tick();
    chk("rst_pre", dout8, 16'h0294);
    #3 reset = 1;
    #1;
    chk("arst_data", dout8, 0);
    chk("arst_cnt", cnt8, 0);
    chk("arst_busy", busy8, 0);
    chk("arst_rdy", rdy8, 1);
    tick();
    reset = 0; lv8 = 1; din8 = 8'h0F; op8 = 0; st8 = 0;
    tick();
    lv8 = 0;
    chk("post_rst_load", dout8, 16'h000F);
    chk("post_rst_busy", busy8, 1);
    lv64 = 1; op64 = 0; din64 = 64'd1;
    tick();
    lv64 = 0;
    chk("w64_load", dout64, 128'd1);
    dones = 0; done_at = -1;
    for (int c = 0; c < 128; c++) begin
      st64 = (c % 2 == 0);
      tick();
      if (done64) begin
        dones++;
        done_at = c;
      end
    end
    st64 = 0;
    chk("w64_data", dout64, 128'd1 << 64);
    chk("w64_cnt", cnt64, 64);
    chk("w64_dones", dones, 1);
    chk("w64_done_at", done_at, 126);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
